pla_sweep_checker: RTL and testbench
====================================

Name: pla_sweep_checker

Overview:
Sequential stimulus/response stage that sits directly upstream and downstream of a combinational PLA-derived logic block (8 inputs x0..x7, single output y0). It drives the DUT inputs exhaustively over all 2^NIN vectors and samples the optimized output alongside a golden (unreduced) reference output and a care-set flag. It accumulates a ones-count, a care-masked mismatch count with the first failing vector, and a MISR signature. This is how don't-care-reduced netlists are checked against originals on the care set.

Parameters:
NIN, 8, number of DUT inputs / vector width
SETTLE, 0, extra cycles each vector is held before sampling (0 = sample in the same cycle the vector is presented)
SIG_W, 16, MISR width
POLY, 16'h1021, MISR feedback taps (x^SIG_W term implicit)

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a sweep; accepted only in IDLE
x  output  NIN  registered DUT input vector; x[0] drives DUT x0
y_dut  input  1  DUT output y0 (optimized netlist)
y_ref  input  1  golden output for the same vector
care  input  1  1 = vector is in the care set; mismatches counted only when 1
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at sweep end
ones_count  output  NIN+1  number of sampled vectors with y_dut=1
mism_count  output  NIN+1  number of care vectors with y_dut!=y_ref
first_mism_valid  output  1  a care mismatch has been recorded
first_mism_vec  output  NIN  vector of the first care mismatch
signature  output  SIG_W  MISR over y_dut

Behaviour:
- Reset (rst=1 at an edge, any state including mid-sweep): state IDLE; x=0, busy=0, done=0, ones_count=0, mism_count=0, first_mism_valid=0, first_mism_vec=0, signature=0. The sweep is abandoned with no partial done.
- FSM: IDLE -> SWEEP -> DONE -> IDLE.
- IDLE: when start=1 (accept edge, "cycle 0"), clear all result registers, x<=0, hold counter<=0, go to SWEEP. start in SWEEP or DONE is ignored and not queued.
- SWEEP: busy=1. Vector k is presented during cycles 1+k(SETTLE+1) through (k+1)(SETTLE+1).
- Hold counter counts 0..SETTLE. A sample happens at the edge where the counter equals SETTLE. At that edge:
  - counter<=0.
  - ones_count += y_dut.
  - If care and y_dut!=y_ref: mism_count += 1. If first_mism_valid=0, then first_mism_vec<=x and first_mism_valid<=1.
  - MISR update: fb=signature[SIG_W-1]; next=(signature<<1) ^ (fb ? POLY : 0); next[0] ^= y_dut.
  - x<=x+1, wrapping modulo 2^NIN.
- When the sample is taken with x all-ones, x wraps to 0 and the state goes to DONE.
- DONE: exactly one cycle, at cycle 2^NIN*(SETTLE+1)+1; done=1, busy=0. Then IDLE.
- Result outputs are live during the sweep and hold their final values in IDLE until the next accepted start or reset.
- Counters are NIN+1 bits, so 2^NIN is representable and there is no saturation or wrap.
- Inputs are sampled only at sample edges. Values of y_dut, y_ref and care between sample edges are don't-care.
- Total sweep latency from accept edge to done: 2^NIN*(SETTLE+1)+1 cycles.

Test Plan:
1. NIN=8, SETTLE=0; y_dut=y_ref=0, care=1; pulse start -> busy high cycles 1..256; done pulses once in cycle 257; ones_count=0, mism_count=0, first_mism_valid=0, signature=16'h0000, x=0.
2. y_dut=x[0], y_ref=x[0], care=1 -> ones_count=128, mism_count=0; x observed stepping 0,1,...,255 one per cycle.
3. y_dut=(x==8'hA5), y_ref=0, care=1 -> mism_count=1, first_mism_vec=8'hA5, first_mism_valid=1, ones_count=1. Repeat with care=0 only at 8'hA5 -> mism_count=0, first_mism_valid=0.
4. y_dut=(x==8'hFF), y_ref=1 only at x=8'h10 and 8'h20, care=1 -> signature=16'h0001, mism_count=3, first_mism_vec=8'h10.
5. SETTLE=2 -> each vector is held 3 cycles, with sampling on the third; done in cycle 769. Starts pulsed in cycles 5 and 769 are ignored, and no second sweep begins.
6. Assert rst for one edge while x=8'h40 mid-sweep -> next cycle all outputs are at reset values and stay idle. A new start then gives a fresh full sweep with results identical to scenario 2.

Source files
------------

// File: rtl/pla_sweep_checker_if.sv
// Bundle of start/status, DUT stimulus/response and result signals for the PLA sweep checker.
// The checker takes the slave side; whoever requests sweeps and hosts the PLA takes master.
interface pla_sweep_checker_if #(
   parameter int NIN   = 8,
   parameter int SIG_W = 16
);
   logic             start;
   logic             busy;
   logic             done;
   logic [NIN-1:0]   x;
   logic             y_dut;
   logic             y_ref;
   logic             care;
   logic [NIN:0]     ones_count;
   logic [NIN:0]     mism_count;
   logic             first_mism_valid;
   logic [NIN-1:0]   first_mism_vec;
   logic [SIG_W-1:0] signature;

   modport master (
      output start, y_dut, y_ref, care,
      input  busy, done, x, ones_count, mism_count,
             first_mism_valid, first_mism_vec, signature
   );

   modport slave (
      input  start, y_dut, y_ref, care,
      output busy, done, x, ones_count, mism_count,
             first_mism_valid, first_mism_vec, signature
   );
endinterface

// File: rtl/pla_sweep_checker.sv
// Exhaustive input sweep of a PLA-derived block, comparing the optimized output to a golden
// reference on the care set and compressing the optimized output into a MISR signature.
module pla_sweep_checker #(
   parameter int                NIN    = 8,
   parameter int                SETTLE = 0,
   parameter int                SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
   input logic clk,
   input logic rst,
   pla_sweep_checker_if.slave bus
);
   localparam int HOLD_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SETTLE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold;
   logic [NIN-1:0]    vec;
   logic              busy_flag;
   logic              done_flag;
   logic [NIN:0]      ones;
   logic [NIN:0]      mism;
   logic              first_valid;
   logic [NIN-1:0]    first_vec;
   logic [SIG_W-1:0]  sig;
   logic [SIG_W-1:0]  sig_next;

   // Left-shifting MISR; the dropped MSB selects the feedback taps and y_dut folds into bit 0.
   always_comb begin
      sig_next    = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0);
      sig_next[0] = sig_next[0] ^ bus.y_dut;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hold        <= '0;
         vec         <= '0;
         busy_flag   <= 1'b0;
         done_flag   <= 1'b0;
         ones        <= '0;
         mism        <= '0;
         first_valid <= 1'b0;
         first_vec   <= '0;
         sig         <= '0;
      end else begin
         done_flag <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= SWEEP;
                  hold        <= '0;
                  vec         <= '0;
                  busy_flag   <= 1'b1;
                  ones        <= '0;
                  mism        <= '0;
                  first_valid <= 1'b0;
                  first_vec   <= '0;
                  sig         <= '0;
               end
            end
            SWEEP: begin
               // Each vector is held SETTLE extra cycles; responses are sampled only on the last one.
               if (hold == HOLD_MAX) begin
                  hold <= '0;
                  ones <= ones + {{NIN{1'b0}}, bus.y_dut};
                  if (bus.care && (bus.y_dut != bus.y_ref)) begin
                     mism <= mism + {{NIN{1'b0}}, 1'b1};
                     if (!first_valid) begin
                        first_valid <= 1'b1;
                        first_vec   <= vec;
                     end
                  end
                  sig <= sig_next;
                  vec <= vec + {{(NIN-1){1'b0}}, 1'b1};
                  if (&vec) begin
                     state     <= DONE;
                     busy_flag <= 1'b0;
                     done_flag <= 1'b1;
                  end
               end else begin
                  hold <= hold + {{(HOLD_W-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.x                = vec;
   assign bus.busy             = busy_flag;
   assign bus.done             = done_flag;
   assign bus.ones_count       = ones;
   assign bus.mism_count       = mism;
   assign bus.first_mism_valid = first_valid;
   assign bus.first_mism_vec   = first_vec;
   assign bus.signature        = sig;
endmodule

// File: tb/tb_pla_sweep_checker.sv
// Bench for pla_sweep_checker: two instances (SETTLE=0 and SETTLE=2) driven by table-selected
// PLA response patterns, with expected sweep results queued at start and compared at done.
module tb_pla_sweep_checker;
   localparam int NIN   = 8;
   localparam int SIG_W = 16;
   localparam logic [SIG_W-1:0] POLY = 16'h1021;
   localparam int NVEC  = 1 << NIN;

   typedef struct {
      logic [NIN:0]     ones;
      logic [NIN:0]     mism;
      logic             fvalid;
      logic [NIN-1:0]   fvec;
      logic [SIG_W-1:0] sig;
   } result_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;
   bit   sel = 1'b0;
   logic start_req = 1'b0;

   int checks = 0;
   int passes = 0;
   result_t expq[$];

   always #5 clk = ~clk;

   pla_sweep_checker_if #(.NIN(NIN), .SIG_W(SIG_W)) if0 ();
   pla_sweep_checker_if #(.NIN(NIN), .SIG_W(SIG_W)) if2 ();

   pla_sweep_checker #(.NIN(NIN), .SETTLE(0), .SIG_W(SIG_W), .POLY(POLY)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave));
   pla_sweep_checker #(.NIN(NIN), .SETTLE(2), .SIG_W(SIG_W), .POLY(POLY)) dut2 (
      .clk(clk), .rst(rst), .bus(if2.slave));

   // Response table standing in for the PLA: {y_dut, y_ref, care} per mode and vector.
   function automatic logic [2:0] resp(input int m, input logic [NIN-1:0] v);
      logic d, r, c;
      d = 1'b0; r = 1'b0; c = 1'b1;
      case (m)
         1: begin d = v[0]; r = v[0]; end
         2: begin d = (v == 8'hA5); end
         3: begin d = (v == 8'hA5); c = (v != 8'hA5); end
         4: begin d = (v == 8'hFF); r = (v == 8'h10) || (v == 8'h20); end
         5: begin d = v[3] ^ v[5]; r = v[3]; c = v[7] | v[0]; end
         default: ;
      endcase
      return {d, r, c};
   endfunction

   assign {if0.y_dut, if0.y_ref, if0.care} = resp(mode, if0.x);
   assign {if2.y_dut, if2.y_ref, if2.care} = resp(mode, if2.x);
   assign if0.start = start_req & ~sel;
   assign if2.start = start_req & sel;

   logic             cur_busy, cur_done, cur_fvalid;
   logic [NIN-1:0]   cur_x, cur_fvec;
   logic [NIN:0]     cur_ones, cur_mism;
   logic [SIG_W-1:0] cur_sig;
   assign cur_busy   = sel ? if2.busy : if0.busy;
   assign cur_done   = sel ? if2.done : if0.done;
   assign cur_x      = sel ? if2.x : if0.x;
   assign cur_ones   = sel ? if2.ones_count : if0.ones_count;
   assign cur_mism   = sel ? if2.mism_count : if0.mism_count;
   assign cur_fvalid = sel ? if2.first_mism_valid : if0.first_mism_valid;
   assign cur_fvec   = sel ? if2.first_mism_vec : if0.first_mism_vec;
   assign cur_sig    = sel ? if2.signature : if0.signature;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic result_t model(input int m);
      result_t e;
      logic [2:0] rsp;
      logic fb;
      e.ones = '0; e.mism = '0; e.fvalid = 1'b0; e.fvec = '0; e.sig = '0;
      for (int v = 0; v < NVEC; v++) begin
         rsp = resp(m, NIN'(v));
         if (rsp[2]) e.ones++;
         if (rsp[0] && (rsp[2] != rsp[1])) begin
            e.mism++;
            if (!e.fvalid) begin
               e.fvalid = 1'b1;
               e.fvec = NIN'(v);
            end
         end
         fb = e.sig[SIG_W-1];
         e.sig = (e.sig << 1) ^ (fb ? POLY : '0);
         e.sig[0] = e.sig[0] ^ rsp[2];
      end
      return e;
   endfunction

   task automatic checkResults(input string tag, input result_t e);
      checkOutput({tag, "_ones"}, 32'(cur_ones), 32'(e.ones));
      checkOutput({tag, "_mism"}, 32'(cur_mism), 32'(e.mism));
      checkOutput({tag, "_fvalid"}, 32'(cur_fvalid), 32'(e.fvalid));
      checkOutput({tag, "_fvec"}, 32'(cur_fvec), 32'(e.fvec));
      checkOutput({tag, "_sig"}, 32'(cur_sig), 32'(e.sig));
   endtask

   // Runs one full sweep on the selected instance; with SETTLE=2 it also pulses stray starts.
   task automatic applyStimulus(input string tag, input int m, input bit s);
      int settle, total, done_cycle, done_count, busy_count, busy_errs, x_errs;
      result_t e;
      mode = m;
      sel = s;
      settle = s ? 2 : 0;
      total = NVEC * (settle + 1);
      done_cycle = -1; done_count = 0; busy_count = 0; busy_errs = 0; x_errs = 0;
      expq.push_back(model(m));
      @(negedge clk);
      start_req = 1'b1;
      for (int c = 1; c <= total + 8; c++) begin
         @(negedge clk);
         start_req = s && (c == 5 || c == total + 1);
         if (cur_busy) begin
            busy_count++;
            if (c > total) busy_errs++;
            if (32'(cur_x) != 32'(((c - 1) / (settle + 1)) % NVEC)) x_errs++;
         end
         if (cur_done) begin
            done_count++;
            done_cycle = c;
            if (expq.size() > 0) begin
               e = expq.pop_front();
               checkResults(tag, e);
               checkOutput({tag, "_x_at_done"}, 32'(cur_x), 32'd0);
               checkOutput({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
            end
         end
      end
      start_req = 1'b0;
      checkOutput({tag, "_done_seen"}, 32'(expq.size()), 32'd0);
      expq.delete();
      checkOutput({tag, "_done_cycle"}, 32'(done_cycle), 32'(total + 1));
      checkOutput({tag, "_done_count"}, 32'(done_count), 32'd1);
      checkOutput({tag, "_busy_cycles"}, 32'(busy_count), 32'(total));
      checkOutput({tag, "_busy_late"}, 32'(busy_errs), 32'd0);
      checkOutput({tag, "_x_step"}, 32'(x_errs), 32'd0);
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(cur_busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(cur_done), 32'd0);
      checkOutput({tag, "_x"}, 32'(cur_x), 32'd0);
      checkOutput({tag, "_ones"}, 32'(cur_ones), 32'd0);
      checkOutput({tag, "_mism"}, 32'(cur_mism), 32'd0);
      checkOutput({tag, "_fvalid"}, 32'(cur_fvalid), 32'd0);
      checkOutput({tag, "_fvec"}, 32'(cur_fvec), 32'd0);
      checkOutput({tag, "_sig"}, 32'(cur_sig), 32'd0);
   endtask

   initial begin
      int waited, activity;
      bit reached;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sel = 1'b0;
      checkIdleZero("reset0");
      sel = 1'b1;
      checkIdleZero("reset2");

      applyStimulus("zero", 0, 1'b0);
      checkOutput("zero_sig_const", 32'(cur_sig), 32'h0000);

      applyStimulus("parity", 1, 1'b0);
      checkOutput("parity_ones_const", 32'(cur_ones), 32'd128);
      checkOutput("parity_mism_const", 32'(cur_mism), 32'd0);

      applyStimulus("a5", 2, 1'b0);
      checkOutput("a5_fvec_const", 32'(cur_fvec), 32'hA5);
      checkOutput("a5_mism_const", 32'(cur_mism), 32'd1);

      applyStimulus("a5_nocare", 3, 1'b0);
      checkOutput("a5_nocare_mism_const", 32'(cur_mism), 32'd0);

      applyStimulus("misr", 4, 1'b0);
      checkOutput("misr_sig_const", 32'(cur_sig), 32'h0001);
      checkOutput("misr_mism_const", 32'(cur_mism), 32'd3);
      checkOutput("misr_fvec_const", 32'(cur_fvec), 32'h10);

      applyStimulus("mixed", 5, 1'b0);

      applyStimulus("settle2", 4, 1'b1);
      checkOutput("settle2_sig_const", 32'(cur_sig), 32'h0001);

      // Abort a sweep at vector 0x40 and confirm it leaves nothing behind.
      mode = 1;
      sel = 1'b0;
      @(negedge clk);
      start_req = 1'b1;
      @(negedge clk);
      start_req = 1'b0;
      reached = 1'b0;
      waited = 0;
      while (!reached && waited < 1000) begin
         if (cur_x == 8'h40) reached = 1'b1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      checkOutput("abort_reach_40", 32'(reached), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkIdleZero("abort");
      activity = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (cur_busy || cur_done) activity++;
      end
      checkOutput("abort_stays_idle", 32'(activity), 32'd0);

      applyStimulus("after_abort", 1, 1'b0);
      checkOutput("after_abort_ones_const", 32'(cur_ones), 32'd128);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
